// File: rtl/enc_pkg.sv
// Shared defaults, mode encoding and shift-table reset helper for the
// sparse HDC encoder binding array.
package enc_pkg;

  localparam int HV_DIM_DEF = 1024;
  localparam int NUM_CH_DEF = 8;

  typedef enum logic {
    BIND   = 1'b0,
    UNBIND = 1'b1
  } bind_mode_e;

  function automatic int default_shift(input int ch, input int dim);
    return ch % dim;
  endfunction

endpackage

// File: rtl/enc_rot_stage.sv
// One binding pipeline stage: rotates every channel by this stage's slice of
// the shift bits (left for bind, right for unbind) and registers the result.
module enc_rot_stage
  import enc_pkg::*;
#(
  parameter int HV_DIM = HV_DIM_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int W      = 5,
  parameter int LO     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           advance_i,
  input  logic                           valid_i,
  input  logic                           mode_i,
  input  logic [NUM_CH-1:0][W-1:0]       slice_i,
  input  logic [NUM_CH-1:0][HV_DIM-1:0]  hv_i,
  output logic                           valid_o,
  output logic [NUM_CH-1:0][HV_DIM-1:0]  hv_o
);

  logic                          valid_q;
  logic [NUM_CH-1:0][HV_DIM-1:0] hv_q;
  logic [NUM_CH-1:0][HV_DIM-1:0] hv_d;

  // Amounts are powers of two; anything >= HV_DIM is a full turn.
  function automatic logic [HV_DIM-1:0] rotate(input logic [HV_DIM-1:0] x,
                                               input bind_mode_e        mode,
                                               input int                amt);
    logic [2*HV_DIM-1:0] dbl;
    int                  r;
    r   = amt % HV_DIM;
    dbl = {x, x};
    if (mode == BIND) dbl = dbl >> (HV_DIM - r);
    else              dbl = dbl >> r;
    return dbl[HV_DIM-1:0];
  endfunction

  always_comb begin
    // NOTE: hv_d gets its default before the loop so no path leaves it unassigned (no latch).
    hv_d = hv_i;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < W; j++) begin
        if (slice_i[c][j]) hv_d[c] = rotate(hv_d[c], bind_mode_e'(mode_i), 1 << (LO + j));
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so stages sample each other's old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      hv_q    <= '0;
    end else if (advance_i) begin
      valid_q <= valid_i;
      hv_q    <= hv_d;
    end
  end

  assign valid_o = valid_q;
  assign hv_o    = hv_q;

endmodule

// File: rtl/enc_binder_array.sv
// Configurable binding array: per-channel shift table, valid/ready front end
// with a global stall, and STAGES rotation stages carrying mode and shifts.
module enc_binder_array
  import enc_pkg::*;
#(
  parameter int HV_DIM  = HV_DIM_DEF,
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int SHIFT_W = $clog2(HV_DIM),
  parameter int STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]     cfg_ch,
  input  logic [SHIFT_W-1:0]            cfg_shift,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [NUM_CH-1:0]             in_ch_mask,
  input  logic [NUM_CH-1:0][HV_DIM-1:0] in_hv,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH-1:0][HV_DIM-1:0] out_hv,
  output logic                          busy
);

  localparam int SLICE_W = (SHIFT_W + STAGES - 1) / STAGES;
  localparam int PAD_W   = SLICE_W * STAGES;

  logic [SHIFT_W-1:0]            shift_q [NUM_CH];
  logic [NUM_CH-1:0][PAD_W-1:0]  shift_pad;
  logic [NUM_CH-1:0][HV_DIM-1:0] hv_cap;
  logic                          advance;
  logic [STAGES-1:0]             stage_valid;
  logic [NUM_CH-1:0][HV_DIM-1:0] stage_hv [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // NOTE: the table is a few flops, so it is async-reset to defaults; a RAM-style array could not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) shift_q[c] <= SHIFT_W'(default_shift(c, HV_DIM));
    end else if (cfg_we && int'(cfg_ch) < NUM_CH) begin
      shift_q[cfg_ch] <= cfg_shift;
    end
  end

  // Masking at capture is equivalent to masking at the output: zero rotates to zero.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      shift_pad[c] = PAD_W'(shift_q[c]);
      hv_cap[c]    = in_ch_mask[c] ? in_hv[c] : '0;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [NUM_CH-1:0][SLICE_W-1:0] slice;
    logic                           mode;
    logic                           valid_in;
    logic [NUM_CH-1:0][HV_DIM-1:0]  hv_in;

    if (k == 0) begin : g_head
      always_comb begin
        for (int c = 0; c < NUM_CH; c++) slice[c] = shift_pad[c][SLICE_W-1:0];
        mode     = in_mode;
        valid_in = in_valid;
        hv_in    = hv_cap;
      end
    end else begin : g_tail
      // Remaining shift slices ride alongside the data, lowest slice first.
      localparam int REM_W = (STAGES - k) * SLICE_W;
      logic [NUM_CH-1:0][REM_W-1:0] rem_q, rem_d;
      logic                         mode_q, mode_d;

      if (k == 1) begin : g_src
        always_comb begin
          for (int c = 0; c < NUM_CH; c++) rem_d[c] = shift_pad[c][PAD_W-1:SLICE_W];
          mode_d = in_mode;
        end
      end else begin : g_src
        always_comb begin
          for (int c = 0; c < NUM_CH; c++)
            rem_d[c] = g_stage[k-1].g_tail.rem_q[c][REM_W+SLICE_W-1:SLICE_W];
          mode_d = g_stage[k-1].g_tail.mode_q;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rem_q  <= '0;
          mode_q <= 1'b0;
        end else if (advance) begin
          rem_q  <= rem_d;
          mode_q <= mode_d;
        end
      end

      always_comb begin
        for (int c = 0; c < NUM_CH; c++) slice[c] = rem_q[c][SLICE_W-1:0];
        mode     = mode_q;
        valid_in = stage_valid[k-1];
        hv_in    = stage_hv[k-1];
      end
    end

    enc_rot_stage #(
      .HV_DIM (HV_DIM),
      .NUM_CH (NUM_CH),
      .W      (SLICE_W),
      .LO     (k * SLICE_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance_i (advance),
      .valid_i   (valid_in),
      .mode_i    (mode),
      .slice_i   (slice),
      .hv_i      (hv_in),
      .valid_o   (stage_valid[k]),
      .hv_o      (stage_hv[k])
    );
  end

  assign out_valid = stage_valid[STAGES-1];
  assign out_hv    = stage_hv[STAGES-1];
  assign busy      = |stage_valid;

endmodule
